// File: rtl/bus_rsp_pkg.sv
// Shared types, default sizes and helpers for the bus responder.
package bus_rsp_pkg;

  // Responder protocol states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WACK  = 2'd1,
    TURN  = 2'd2,
    DRIVE = 2'd3
  } state_t;

  localparam int DEF_DW   = 3;
  localparam int DEF_AW   = 2;
  localparam int DEF_NREG = 4;

  // Even-parity bit: the bit that makes the total count of ones even.
  // Callers zero-extend their vector, which does not change the parity.
  function automatic logic even_par(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/bus_rsp_regfile.sv
// NREG x DW register file with a bus write port (priority) and a local
// device write port; contents are exposed flattened, reg0 in the LSBs.
module bus_rsp_regfile
  import bus_rsp_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int AW   = DEF_AW,
  parameter int NREG = DEF_NREG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bus_we,
  input  logic [AW-1:0]        bus_addr,
  input  logic [DW-1:0]        bus_wdata,
  input  logic                 dev_we,
  input  logic [AW-1:0]        dev_addr,
  input  logic [DW-1:0]        dev_wdata,
  output logic [NREG*DW-1:0]   rdata
);

  logic [DW-1:0] regs [NREG];

  // Storage update; a bus write to the same register as a local write wins,
  // and addresses with no matching register are simply dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (bus_we && bus_addr == AW'(i))
          regs[i] <= bus_wdata;
        else if (dev_we && dev_addr == AW'(i))
          regs[i] <= dev_wdata;
      end
    end
  end

  // Flatten the array for the device-side read-out
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREG; i++) rdata[i*DW +: DW] = regs[i];
  end

endmodule

// File: rtl/bus_responder.sv
// Responder end of the tristate req/ack bus: register file target with a
// one-cycle read turnaround and a local device write port.
// Optional build macro BUSRSP_PARITY_EN adds write-data parity checking
// (data_par) and a read parity output (rd_par).
module bus_responder
  import bus_rsp_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int AW   = DEF_AW,
  parameter int NREG = DEF_NREG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic                 rw,
  input  logic [AW-1:0]        addr,
  inout  wire  [DW-1:0]        data,
`ifdef BUSRSP_PARITY_EN
  input  logic                 data_par,
  output wire                  rd_par,
`endif
  output logic                 ack,
  output logic                 err,
  output logic                 busy,
  input  logic                 dev_we,
  input  logic [AW-1:0]        dev_addr,
  input  logic [DW-1:0]        dev_wdata,
  output logic [NREG*DW-1:0]   dev_rdata
);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic          err_q;
  logic [DW-1:0] snap_q;
  logic [DW-1:0] rd_sel;
  logic          addr_hit;
  logic          par_ok;
  logic          bus_we;
  logic          drive_en;

  assign addr_hit = ({1'b0, addr} < (AW+1)'(NREG));

`ifdef BUSRSP_PARITY_EN
  assign par_ok = (even_par(32'(data)) == data_par);
  assign rd_par = drive_en ? even_par(32'(snap_q)) : 1'bz;
`else
  assign par_ok = 1'b1;
`endif

  // Bus is only ever driven from the snapshot while in DRIVE; state resets
  // asynchronously so the bus and ack drop the moment rst_n falls
  assign data = drive_en ? snap_q : {DW{1'bz}};
  assign busy = (state_q != IDLE);

  // Next-state and handshake outputs
  always_comb begin
    state_d  = state_q;
    ack      = 1'b0;
    err      = 1'b0;
    bus_we   = 1'b0;
    drive_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (rw) begin
            state_d = TURN;
          end else begin
            state_d = WACK;
            bus_we  = addr_hit && par_ok;
          end
        end
      end
      WACK: begin
        ack = 1'b1;
        err = err_q;
        if (!req) state_d = IDLE;
      end
      TURN: state_d = DRIVE;
      DRIVE: begin
        ack      = 1'b1;
        err      = err_q;
        drive_en = 1'b1;
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus request capture; addr/err are frozen until the next IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        addr_q <= addr;
        err_q  <= !addr_hit || (!rw && !par_ok);
      end
    end
  end

  // Select the addressed register for the read snapshot
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NREG; i++)
      if (addr_q == AW'(i)) rd_sel = dev_rdata[i*DW +: DW];
  end

  // Read snapshot taken on DRIVE entry so later local writes cannot disturb the bus
  always_ff @(posedge clk) begin
    if (state_q == TURN) snap_q <= err_q ? '0 : rd_sel;
  end

  bus_rsp_regfile #(
    .DW   (DW),
    .AW   (AW),
    .NREG (NREG)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_we    (bus_we),
    .bus_addr  (addr),
    .bus_wdata (data),
    .dev_we    (dev_we),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .rdata     (dev_rdata)
  );

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder (NREG=3 so address 3 is unmapped).
// Pull-ups on the shared bus make an undriven bus read back as all ones.
module tb_bus_responder;

  localparam int DW   = 3;
  localparam int AW   = 2;
  localparam int NREG = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, req, rw, dev_we, tb_drv_en, data_par;
  logic [AW-1:0]        addr, dev_addr;
  logic [DW-1:0]        tb_wdata, dev_wdata;
  wire  [DW-1:0]        data;
  logic                 ack, err, busy;
  logic [NREG*DW-1:0]   dev_rdata;
`ifdef BUSRSP_PARITY_EN
  wire                  rd_par;
  pullup (rd_par);
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl [NREG];
  typedef struct packed { logic [DW-1:0] d; logic e; } exp_t;
  exp_t sb[$];

  assign data = tb_drv_en ? tb_wdata : {DW{1'bz}};
  pullup (data[0]);
  pullup (data[1]);
  pullup (data[2]);

  bus_responder #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rw        (rw),
    .addr      (addr),
    .data      (data),
`ifdef BUSRSP_PARITY_EN
    .data_par  (data_par),
    .rd_par    (rd_par),
`endif
    .ack       (ack),
    .err       (err),
    .busy      (busy),
    .dev_we    (dev_we),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREG*DW-1:0] flat();
    logic [NREG*DW-1:0] f;
    for (int i = 0; i < NREG; i++) f[i*DW +: DW] = mdl[i];
    return f;
  endfunction

  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic dp,
                           input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dd);
    int n;
    exp_t e;
    logic bad;
    bad = (int'(a) >= NREG);
`ifdef BUSRSP_PARITY_EN
    if (dp != ^wd) bad = 1'b1;
`endif
    @(negedge clk);
    req = 1'b1; rw = 1'b0; addr = a; tb_wdata = wd; tb_drv_en = 1'b1; data_par = dp;
    dev_we = dwe; dev_addr = da; dev_wdata = dd;
    if (dwe && int'(da) < NREG) mdl[da] = dd;
    if (!bad) mdl[a] = wd;
    sb.push_back('{d: wd, e: bad});
    n = 0;
    do begin
      @(negedge clk);
      n++;
      dev_we = 1'b0; addr = ~a; tb_wdata = ~wd;
    end while (!ack && n < 8);
    e = sb.pop_front();
    chk("wr_latency", n, 1);
    chk("wr_ack", ack, 1'b1);
    chk("wr_err", err, e.e);
    chk("wr_busy", busy, 1'b1);
    chk("wr_regs", dev_rdata, flat());
    @(negedge clk);
    chk("wr_hold_ack", ack, 1'b1);
    chk("wr_hold_regs", dev_rdata, flat());
    req = 1'b0; tb_drv_en = 1'b0;
    @(negedge clk);
    chk("wr_rel_ack", ack, 1'b0);
    chk("wr_rel_busy", busy, 1'b0);
  endtask

  task automatic bus_read(input logic [AW-1:0] a, input logic poke);
    int n;
    exp_t e;
    logic mapped;
    mapped = (int'(a) < NREG);
    @(negedge clk);
    req = 1'b1; rw = 1'b1; addr = a; tb_drv_en = 1'b0;
    sb.push_back('{d: (mapped ? mdl[a] : '0), e: !mapped});
    @(negedge clk);
    rw = 1'b0; addr = ~a;
    chk("turn_ack", ack, 1'b0);
    chk("turn_bus", data, 3'b111);
    chk("turn_busy", busy, 1'b1);
`ifdef BUSRSP_PARITY_EN
    chk("turn_rdpar", rd_par, 1'b1);
`endif
    n = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    e = sb.pop_front();
    chk("rd_latency", n, 2);
    chk("rd_data", data, e.d);
    chk("rd_err", err, e.e);
`ifdef BUSRSP_PARITY_EN
    chk("rd_par", rd_par, ^e.d);
`endif
    if (poke && mapped) begin
      dev_we = 1'b1; dev_addr = a; dev_wdata = ~e.d;
      mdl[a] = ~e.d;
      @(negedge clk);
      dev_we = 1'b0;
      chk("rd_snap_hold", data, e.d);
      chk("rd_poke_regs", dev_rdata, flat());
    end
    req = 1'b0;
    @(negedge clk);
    chk("rd_rel_bus", data, 3'b111);
    chk("rd_rel_ack", ack, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; req = 1'b0; rw = 1'b0; addr = '0; tb_drv_en = 1'b0; tb_wdata = '0;
    data_par = 1'b0; dev_we = 1'b0; dev_addr = '0; dev_wdata = '0;
    for (int i = 0; i < NREG; i++) mdl[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bus", data, 3'b111);
    chk("rst_regs", dev_rdata, '0);
    rst_n = 1'b1;

    bus_write(2'd2, 3'b101, 1'b0, 1'b0, 2'd0, 3'b000);
    chk("reg2_101", dev_rdata[8:6], 3'b101);
    bus_read(2'd2, 1'b1);

    bus_write(2'd3, 3'b111, 1'b1, 1'b0, 2'd0, 3'b000);
    bus_read(2'd3, 1'b0);

    bus_write(2'd1, 3'b010, 1'b1, 1'b1, 2'd1, 3'b110);
    chk("coll_same_reg1", dev_rdata[5:3], 3'b010);
    bus_write(2'd1, 3'b010, 1'b1, 1'b1, 2'd0, 3'b110);
    chk("coll_diff_reg0", dev_rdata[2:0], 3'b110);
    chk("coll_diff_reg1", dev_rdata[5:3], 3'b010);

    // Reset in the middle of a read
    @(negedge clk);
    req = 1'b1; rw = 1'b1; addr = 2'd1;
    sb.push_back('{d: mdl[1], e: 1'b0});
    repeat (2) @(negedge clk);
    e = sb.pop_front();
    chk("mid_ack", ack, 1'b1);
    chk("mid_data", data, e.d);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bus", data, 3'b111);
    chk("mid_rst_ack", ack, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_regs", dev_rdata, '0);
    for (int i = 0; i < NREG; i++) mdl[i] = '0;
    @(negedge clk);
    req = 1'b0; rst_n = 1'b1;
    bus_read(2'd1, 1'b0);

`ifdef BUSRSP_PARITY_EN
    bus_write(2'd0, 3'b011, 1'b1, 1'b0, 2'd0, 3'b000);
    chk("par_bad_reg0", dev_rdata[2:0], 3'b000);
    bus_write(2'd0, 3'b011, 1'b0, 1'b0, 2'd0, 3'b000);
    bus_read(2'd0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
